vga_screen_ctrl: RTL and testbench
==================================

Name: vga_screen_ctrl

Overview:
- Owns VGA 640x480@60 timing for the game display and sequences which pixel source drives the monitor: start screen (O/X title art), game board, or game-over screen.
- Generates the pixel scan coordinates consumed by the combinational RGB generators, then selects and registers their RGB.
- Realigns hsync/vsync to the registered RGB.
- Screen changes are deferred to frame boundaries so no frame tears.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel rate)
- BLINK_FRAMES, 30, frames per blink half-period on the game-over screen

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  debounced start button, level; rising edge detected internally
- game_over  in  1  level from game logic; high = game finished
- start_r, start_g, start_b  in  4 each  start-screen RGB for current x/y
- game_r, game_g, game_b  in  4 each  board RGB for current x/y
- x  out  10  current pixel column, 0..639 while visible
- y  out  9  current pixel row, 0..479 while visible
- pix_tick  out  1  one-clk pulse per pixel
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- vga_r, vga_g, vga_b  out  4 each  registered RGB to DAC
- screen  out  2  current screen: 0 START, 1 PLAY, 2 OVER

Behaviour:
- Reset values:
  - div/h/v counters 0, x=0, y=0, pix_tick=0
  - hsync=1, vsync=1, vga_r/g/b=0
  - screen=START, pending=0, blink_on=1, frame_cnt=0, btn_start edge register=0
- Pixel divider:
  - Counts 0..PIX_DIV-1; pix_tick=1 in the clk where the divider equals PIX_DIV-1.
  - All timing state below advances only on pix_tick.
- Timing counters:
  - h_cnt 0..799 wraps to 0; on wrap, v_cnt increments 0..524 and wraps to 0. v_cnt is 10 bits internally.
  - x=h_cnt, y=v_cnt[8:0]; both are valid only when video_on (h_cnt<640 && v_cnt<480).
  - hsync low for h_cnt in 656..751; vsync low for v_cnt in 490..491.
- Pipeline:
  - Source RGB is combinational from x/y.
  - Stage 1 registers the selected RGB plus raw hsync/vsync/video_on on pix_tick, so all outputs share 1 pixel of latency.
  - RGB is forced to 0 when delayed video_on=0.
- RGB select:
  - START -> start_*; PLAY -> game_*.
  - OVER -> game_* when blink_on=1, else 0.
- Frame boundary: the pix_tick where h_cnt=799 and v_cnt=524.
- FSM request sources:
  - START: rising edge of btn_start sets pending (target PLAY).
  - PLAY: game_over=1 sets pending (target OVER).
  - OVER: btn_start rising edge sets pending (target START).
- Commit: at the frame boundary, if pending, screen<=target and pending<=0.
  - A request arriving in the same clk as the boundary is committed at that boundary.
  - Repeated requests before commit are idempotent.
- Entering OVER: blink_on<=1 and frame_cnt<=0.
- While in OVER: frame_cnt increments per frame boundary; at BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
- Outside OVER: blink_on=1 and frame_cnt=0.
- game_over deasserting while pending toward OVER does not cancel the request.
- rst mid-frame: all state returns to reset values on the next clk; scanning restarts at h=0, v=0.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants
  - screen encoding localparams (SCR_START=0, SCR_PLAY=1, SCR_OVER=2)
  - 4-bit colour width
- Sub-module vga_timing: divider, h/v counters, raw sync, video_on, x/y.
- Screen FSM, blink logic and output register stay in vga_screen_ctrl.

Test Plan:
- Reset, then run 2 frames with PIX_DIV=2 -> pix_tick every 2 clk; hsync low exactly 96 ticks per 800; vsync low 2 lines per 525; 420000 ticks per frame.
- start_*=13/5/13 constant, screen START -> vga_* =13/5/13 one tick after x=0,y=0; vga_*=0 while h_cnt>=640 or v_cnt>=480.
- Pulse btn_start at v_cnt=100 -> screen stays 0 until the frame boundary, then 1; first PLAY pixel shows game_*.
- In PLAY, game_over=1 for 1 clk at v_cnt=300 -> screen=2 at the next boundary; game_*=0/12/12 shown 30 frames, black 30 frames, repeating.
- btn_start rising edge coincident with the frame-boundary pix_tick in OVER -> screen=0 at that boundary.
- rst asserted at h_cnt=400, v_cnt=200 in PLAY -> next clk: screen=0, hsync=vsync=1, vga_*=0, counters 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, screen encoding and colour types.
// Used by the timing generator and the screen controller.
package vga_pkg;

   localparam int H_VISIBLE    = 640;
   localparam int H_FRONT      = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BACK       = 48;
   localparam int V_VISIBLE    = 480;
   localparam int V_FRONT      = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BACK       = 33;
   localparam int PIX_DIV      = 2;
   localparam int BLINK_FRAMES = 30;
   localparam int COLOR_W      = 4;

   typedef logic [1:0] scr_t;

   localparam scr_t SCR_START = 2'd0;
   localparam scr_t SCR_PLAY  = 2'd1;
   localparam scr_t SCR_OVER  = 2'd2;

   typedef logic [COLOR_W-1:0] color_t;

   typedef struct packed {
      color_t r;
      color_t g;
      color_t b;
   } rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, horizontal/vertical scan counters and raw sync.
// Everything past the divider advances once per pix_tick.
module vga_timing #(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK,
   parameter int PIX_DIV   = vga_pkg::PIX_DIV
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_tick,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       video_on,
   output logic       frame_end
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] H_VIS_C = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_C = 10'(V_VISIBLE);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;

   assign pix_tick = (div_q == DIV_W'(PIX_DIV - 1));

   always_comb begin
      div_d = pix_tick ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   assign x         = h_q;
   assign y         = v_q[8:0];
   assign hsync_raw = !(h_q >= HS_BEG && h_q < HS_END);
   assign vsync_raw = !(v_q >= VS_BEG && v_q < VS_END);
   assign video_on  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
   assign frame_end = pix_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_screen_ctrl.sv
// VGA screen sequencer: start / play / game-over source select,
// frame-aligned screen changes, blink and registered RGB + sync.
module vga_screen_ctrl #(
   parameter int H_VISIBLE    = vga_pkg::H_VISIBLE,
   parameter int H_FRONT      = vga_pkg::H_FRONT,
   parameter int H_SYNC       = vga_pkg::H_SYNC,
   parameter int H_BACK       = vga_pkg::H_BACK,
   parameter int V_VISIBLE    = vga_pkg::V_VISIBLE,
   parameter int V_FRONT      = vga_pkg::V_FRONT,
   parameter int V_SYNC       = vga_pkg::V_SYNC,
   parameter int V_BACK       = vga_pkg::V_BACK,
   parameter int PIX_DIV      = vga_pkg::PIX_DIV,
   parameter int BLINK_FRAMES = vga_pkg::BLINK_FRAMES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn_start,
   input  logic                       game_over,
   input  logic [vga_pkg::COLOR_W-1:0] start_r,
   input  logic [vga_pkg::COLOR_W-1:0] start_g,
   input  logic [vga_pkg::COLOR_W-1:0] start_b,
   input  logic [vga_pkg::COLOR_W-1:0] game_r,
   input  logic [vga_pkg::COLOR_W-1:0] game_g,
   input  logic [vga_pkg::COLOR_W-1:0] game_b,
   output logic [9:0]                 x,
   output logic [8:0]                 y,
   output logic                       pix_tick,
   output logic                       hsync,
   output logic                       vsync,
   output logic [vga_pkg::COLOR_W-1:0] vga_r,
   output logic [vga_pkg::COLOR_W-1:0] vga_g,
   output logic [vga_pkg::COLOR_W-1:0] vga_b,
   output logic [1:0]                 screen
);

   import vga_pkg::*;

   localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

   logic hs_raw, vs_raw, video_on, frame_end;

   vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK),
      .PIX_DIV   (PIX_DIV)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .pix_tick  (pix_tick),
      .x         (x),
      .y         (y),
      .hsync_raw (hs_raw),
      .vsync_raw (vs_raw),
      .video_on  (video_on),
      .frame_end (frame_end)
   );

   scr_t            screen_q, screen_d, target;
   logic            pending_q, pending_d;
   logic            btn_q, btn_d;
   logic            blink_q, blink_d;
   logic [FC_W-1:0] cnt_q, cnt_d;
   rgb_t            rgb_q, rgb_d, src;
   logic            hs_q, hs_d, vs_q, vs_d;
   logic            btn_rise, req;

   assign btn_rise = btn_start && !btn_q;

   always_comb begin
      target = SCR_START;
      req    = 1'b0;
      case (screen_q)
         SCR_START: begin
            target = SCR_PLAY;
            req    = btn_rise;
         end
         SCR_PLAY: begin
            target = SCR_OVER;
            req    = game_over;
         end
         SCR_OVER: begin
            target = SCR_START;
            req    = btn_rise;
         end
         default: ;
      endcase
   end

   // A request seen in the boundary clk itself still commits there.
   always_comb begin
      btn_d     = btn_start;
      pending_d = pending_q || req;
      screen_d  = screen_q;
      if (frame_end && pending_d) begin
         screen_d  = target;
         pending_d = 1'b0;
      end
      blink_d = blink_q;
      cnt_d   = cnt_q;
      if (frame_end && screen_q == SCR_OVER) begin
         if (cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            cnt_d   = '0;
            blink_d = !blink_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (screen_d != SCR_OVER) begin
         blink_d = 1'b1;
         cnt_d   = '0;
      end
   end

   always_comb begin
      src = '0;
      case (screen_q)
         SCR_START: src = '{r: start_r, g: start_g, b: start_b};
         SCR_PLAY:  src = '{r: game_r, g: game_g, b: game_b};
         SCR_OVER: begin
            if (blink_q)
               src = '{r: game_r, g: game_g, b: game_b};
         end
         default: ;
      endcase
   end

   always_comb begin
      rgb_d = rgb_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      if (pix_tick) begin
         rgb_d = video_on ? src : '0;
         hs_d  = hs_raw;
         vs_d  = vs_raw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         screen_q  <= SCR_START;
         pending_q <= 1'b0;
         btn_q     <= 1'b0;
         blink_q   <= 1'b1;
         cnt_q     <= '0;
         rgb_q     <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
      end else begin
         screen_q  <= screen_d;
         pending_q <= pending_d;
         btn_q     <= btn_d;
         blink_q   <= blink_d;
         cnt_q     <= cnt_d;
         rgb_q     <= rgb_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
      end
   end

   assign vga_r  = rgb_q.r;
   assign vga_g  = rgb_q.g;
   assign vga_b  = rgb_q.b;
   assign hsync  = hs_q;
   assign vsync  = vs_q;
   assign screen = screen_q;

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// Bench for vga_screen_ctrl: a shrunken 15x8 raster for screen/blink
// sequencing plus a default 640x480 instance for line timing.
module tb_vga_screen_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_start = 1'b0;
   logic game_over = 1'b0;
   logic [3:0] start_r = 4'd13, start_g = 4'd5, start_b = 4'd13;
   logic [3:0] game_r = 4'd0, game_g = 4'd12, game_b = 4'd12;

   logic [9:0] x, d_x;
   logic [8:0] y, d_y;
   logic pix_tick, hsync, vsync, d_pix_tick, d_hsync, d_vsync;
   logic [3:0] vga_r, vga_g, vga_b, d_r, d_g, d_b;
   logic [1:0] screen, d_screen;

   // Small raster: H 8+2+3+2=15, V 4+1+2+1=8, 120 pixels per frame.
   vga_screen_ctrl #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .PIX_DIV(2), .BLINK_FRAMES(3)
   ) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .game_over(game_over),
      .start_r(start_r), .start_g(start_g), .start_b(start_b),
      .game_r(game_r), .game_g(game_g), .game_b(game_b),
      .x(x), .y(y), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .screen(screen)
   );

   vga_screen_ctrl dut_def (
      .clk(clk), .rst(rst), .btn_start(btn_start), .game_over(game_over),
      .start_r(start_r), .start_g(start_g), .start_b(start_b),
      .game_r(game_r), .game_g(game_g), .game_b(game_b),
      .x(d_x), .y(d_y), .pix_tick(d_pix_tick), .hsync(d_hsync),
      .vsync(d_vsync), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
      .screen(d_screen)
   );

   always #5 clk = ~clk;

   // k = clk edges since reset released; pixel index = k/2
   int k = 0;
   always @(posedge clk) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   int d_hs_low = 0, d_ticks = 0, hs_low_s = 0, vs_low_s = 0;
   always @(negedge clk) begin
      if (!rst && k >= 1 && k <= 1600) begin
         d_ticks <= d_ticks + int'(d_pix_tick);
         if (k % 2 == 1) d_hs_low <= d_hs_low + int'(!d_hsync);
      end
      if (!rst && k % 2 == 0 && k / 2 >= 121 && k / 2 <= 240) begin
         hs_low_s <= hs_low_s + int'(!hsync);
         vs_low_s <= vs_low_s + int'(!vsync);
      end
   end

   int passed = 0, total = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic wait_px(input int t);
      int guard = 0;
      while (k < 2 * t && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (k != 2 * t) begin
         total++;
         $display("FAIL wait_px: k=%0d target %0d", k, 2 * t);
      end
   endtask

   typedef struct {
      int t;
      int x;
      int y;
      int hs;
      int vs;
      int r;
      int g;
      int b;
   } vec_t;

   vec_t tbl[14];
   int   blink_exp[7];

   initial begin
      tbl[0]  = '{0,   0,  0, 1, 1, 0,  0, 0};
      tbl[1]  = '{1,   1,  0, 1, 1, 13, 5, 13};
      tbl[2]  = '{8,   8,  0, 1, 1, 13, 5, 13};
      tbl[3]  = '{9,   9,  0, 1, 1, 0,  0, 0};
      tbl[4]  = '{11,  11, 0, 0, 1, 0,  0, 0};
      tbl[5]  = '{13,  13, 0, 0, 1, 0,  0, 0};
      tbl[6]  = '{14,  14, 0, 1, 1, 0,  0, 0};
      tbl[7]  = '{16,  1,  1, 1, 1, 13, 5, 13};
      tbl[8]  = '{61,  1,  4, 1, 1, 0,  0, 0};
      tbl[9]  = '{76,  1,  5, 1, 0, 0,  0, 0};
      tbl[10] = '{105, 0,  7, 1, 0, 0,  0, 0};
      tbl[11] = '{106, 1,  7, 1, 1, 0,  0, 0};
      tbl[12] = '{121, 1,  0, 1, 1, 13, 5, 13};
      tbl[13] = '{122, 2,  0, 1, 1, 13, 5, 13};
      blink_exp = '{12, 12, 12, 0, 0, 0, 12};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         wait_px(tbl[i].t);
         chk($sformatf("x@%0d", tbl[i].t), int'(x), tbl[i].x);
         chk($sformatf("y@%0d", tbl[i].t), int'(y), tbl[i].y);
         chk($sformatf("hsync@%0d", tbl[i].t), int'(hsync), tbl[i].hs);
         chk($sformatf("vsync@%0d", tbl[i].t), int'(vsync), tbl[i].vs);
         chk($sformatf("r@%0d", tbl[i].t), int'(vga_r), tbl[i].r);
         chk($sformatf("g@%0d", tbl[i].t), int'(vga_g), tbl[i].g);
         chk($sformatf("b@%0d", tbl[i].t), int'(vga_b), tbl[i].b);
         chk($sformatf("tick@%0d", tbl[i].t), int'(pix_tick), 0);
         chk($sformatf("screen@%0d", tbl[i].t), int'(screen), 0);
      end
      @(negedge clk);
      chk("tick_odd", int'(pix_tick), 1);

      // start press mid-frame waits for the frame boundary
      wait_px(153);
      btn_start = 1'b1;
      @(negedge clk);
      btn_start = 1'b0;
      wait_px(200);
      chk("start_hold", int'(screen), 0);
      wait_px(239);
      chk("start_last", int'(screen), 0);
      wait_px(240);
      chk("play_commit", int'(screen), 1);
      wait_px(241);
      chk("play_r", int'(vga_r), 0);
      chk("play_g", int'(vga_g), 12);
      chk("play_b", int'(vga_b), 12);
      chk("small_hs_low", hs_low_s, 24);
      chk("small_vs_low", vs_low_s, 30);

      // one-clk game_over pulse is remembered until the boundary
      wait_px(273);
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      wait_px(359);
      chk("over_hold", int'(screen), 1);
      wait_px(360);
      chk("over_commit", int'(screen), 2);

      for (int f = 3; f <= 9; f++) begin
         wait_px(f * 120 + 1);
         chk($sformatf("blink_g_f%0d", f), int'(vga_g), blink_exp[f-3]);
         chk($sformatf("blink_scr_f%0d", f), int'(screen), 2);
      end
      chk("def_ticks_line", d_ticks, 800);
      chk("def_hs_low_line", d_hs_low, 96);

      // rising edge in the very boundary clk commits at that boundary
      wait_px(1199);
      @(negedge clk);
      chk("bnd_tick", int'(pix_tick), 1);
      chk("bnd_pre", int'(screen), 2);
      btn_start = 1'b1;
      @(negedge clk);
      chk("bnd_commit", int'(screen), 0);
      btn_start = 1'b0;
      wait_px(1201);
      chk("restart_r", int'(vga_r), 13);

      // repeated presses before commit are idempotent
      wait_px(1220);
      btn_start = 1'b1;
      @(negedge clk);
      btn_start = 1'b0;
      wait_px(1250);
      btn_start = 1'b1;
      @(negedge clk);
      btn_start = 1'b0;
      wait_px(1319);
      chk("replay_hold", int'(screen), 0);
      wait_px(1320);
      chk("replay_commit", int'(screen), 1);

      // mid-frame reset in PLAY
      wait_px(1354);
      chk("pre_rst_g", int'(vga_g), 12);
      chk("pre_rst_x", int'(x), 4);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_screen", int'(screen), 0);
      chk("rst_hs", int'(hsync), 1);
      chk("rst_vs", int'(vsync), 1);
      chk("rst_g", int'(vga_g), 0);
      chk("rst_b", int'(vga_b), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_tick", int'(pix_tick), 0);
      chk("rst_def_x", int'(d_x), 0);
      rst = 1'b0;
      wait_px(1);
      chk("post_rst_x", int'(x), 1);
      chk("post_rst_r", int'(vga_r), 13);
      chk("post_rst_scr", int'(screen), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
